// File: rtl/mem_pkg.sv
// Shared types and constants for the RV32I load/store unit and its load aligner.
package mem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_B    = 4'b0001;
  localparam logic [3:0] LANE_H    = 4'b0011;
  localparam logic [3:0] LANE_W    = 4'b1111;

  // Illegal width codes and misaligned halfword/word addresses both report an error.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (we) illegal = (funct3 > F3_W);
    else    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half of a DRAM word and extends it.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] spo,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = spo >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo[1] ? spo[31:16] : spo[15:0];
    rdata    = 32'h0;
    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata = {24'h0, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata = {16'h0, half_sel};
      F3_W:    rdata = spo;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding RV32I load/store unit in front of a registered-read DRAM.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// response side holds valid and payload stable until the consumer's ready.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] dram_a,
  output logic [3:0]            dram_we,
  output logic [31:0]           dram_din,
  input  logic [31:0]           dram_spo,
  output logic [1:0]            dbg_state
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  we_q, we_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] load_rdata;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic        unused_addr_hi;

  // Bits above the DRAM window are architecturally ignored.
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  lsu_load_align u_align (
    .spo     (dram_spo),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .rdata   (load_rdata)
  );

  always_comb begin
    lane_mask = LANE_NONE;
    lane_data = 32'h0;
    case (funct3_q[1:0])
      2'b00: begin
        lane_mask = LANE_B << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask = LANE_H << addr_q[1:0];
        lane_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        lane_mask = LANE_W;
        lane_data = wdata_q;
      end
      default: begin
        lane_mask = LANE_NONE;
        lane_data = 32'h0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr[ADDR_WIDTH+1:0];
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          we_d     = req_we;
          rdata_d  = 32'h0;
          err_d    = access_err(req_we, req_funct3, req_addr[1:0]);
          state_d  = err_d ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS:  state_d = we_q ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: begin
        rdata_d = load_rdata;
        state_d = ST_RESP;
      end
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs are gated by rst_n so an asserted reset takes effect within the same cycle.
  logic store_access;
  assign store_access = rst_n && (state_q == ST_ACCESS) && we_q;

  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign rsp_valid = rst_n && (state_q == ST_RESP);
  assign rsp_rdata = rst_n ? rdata_q : 32'h0;
  assign rsp_err   = rst_n && err_q;
  assign dram_a    = rst_n ? addr_q[ADDR_WIDTH+1:2] : '0;
  assign dram_we   = store_access ? lane_mask : LANE_NONE;
  assign dram_din  = store_access ? lane_data : 32'h0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a byte-addressed memory model.
module tb_mem_access_unit;

  localparam int AW = 16;
  localparam int unsigned BYTE_MASK = (32'd1 << (AW + 2)) - 1;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_funct3;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] dram_a;
  logic [3:0]    dram_we;
  logic [31:0]   dram_din;
  logic [31:0]   dram_spo;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int we_seen = 0;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dram_a     (dram_a),
    .dram_we    (dram_we),
    .dram_din   (dram_din),
    .dram_spo   (dram_spo),
    .dbg_state  (dbg_state)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model: registered read of the old word, byte-lane write.
  logic [31:0] dmem [int unsigned];
  logic [31:0] dram_old;
  logic [31:0] dram_new;
  initial dram_spo = 32'h0;
  always @(posedge clk) begin
    dram_old = dmem.exists(int'(dram_a)) ? dmem[int'(dram_a)] : 32'h0;
    dram_new = dram_old;
    for (int l = 0; l < 4; l++)
      if (dram_we[l]) dram_new[8*l +: 8] = dram_din[8*l +: 8];
    if (dram_we != 4'b0000) dmem[int'(dram_a)] = dram_new;
    dram_spo <= dram_old;
  end

  always @(negedge clk) if (dram_we != 4'b0000) we_seen++;

  // Reference model: flat byte memory and RV32I access rules.
  logic [7:0] bmem [int unsigned];

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    sz = acc_size(f3);
    return (addr % sz) != 0;
  endfunction

  function automatic logic [7:0] rd_byte(input int unsigned a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < acc_size(f3); i++)
      bmem[((addr & BYTE_MASK) + i) & BYTE_MASK] = data[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int sz;
    sz = acc_size(f3);
    v = 32'h0;
    for (int i = 0; i < sz; i++)
      v[8*i +: 8] = rd_byte(((addr & BYTE_MASK) + i) & BYTE_MASK);
    if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one full transaction, starting and ending #1 after a rising edge in IDLE.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, output logic [31:0] got);
    logic        e_err;
    int          lat;
    int          seen0;
    logic [31:0] e_rdata;
    logic [3:0]  e_we;
    logic [31:0] e_din;
    e_err   = ref_err(we, f3, addr);
    lat     = e_err ? 1 : (we ? 2 : 3);
    e_rdata = (e_err || we) ? 32'h0 : ref_load(f3, addr);
    e_we    = 4'b0000;
    if (we) for (int i = 0; i < acc_size(f3); i++) e_we[(addr + i) % 4] = 1'b1;
    e_din = (f3[1:0] == 2'b00) ? {4{wdata[7:0]}} :
            (f3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
    seen0 = we_seen;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1 && !e_err) begin
        chk("access_dram_a", {16'h0, dram_a}, (addr & BYTE_MASK) >> 2);
        chk("access_dram_we", {28'h0, dram_we}, {28'h0, e_we});
        if (we) chk("access_dram_din", dram_din, e_din);
      end
      chk("rsp_valid_latency", {31'h0, rsp_valid}, (c == lat) ? 32'h1 : 32'h0);
    end
    if (e_err) chk("err_no_write", we_seen, seen0);
    if (we && !e_err) ref_store(f3, addr, wdata);
    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e_err});
    chk("rsp_rdata", rsp_rdata, e_rdata);
    got = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold_rsp_rdata", rsp_rdata, e_rdata);
      chk("hold_rsp_err", {31'h0, rsp_err}, {31'h0, e_err});
      chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("after_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("after_req_ready", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h0);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    chk({tag, "_dram_a"}, {16'h0, dram_a}, 32'h0);
    chk({tag, "_dram_we"}, {28'h0, dram_we}, 32'h0);
    chk({tag, "_dram_din"}, dram_din, 32'h0);
  endtask

  logic [31:0] got;
  logic [31:0] r_addr;
  logic [31:0] before_val;
  logic [2:0]  r_f3;
  logic        r_we;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_funct3 = 3'b000; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    #1;

    do_op(1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 0, got);
    chk("sw_rsp_rdata_zero", got, 32'h0);
    do_op(1'b0, 3'b000, 32'h0000_2007, 32'h0, 0, got);
    chk("lb_2007", got, 32'hFFFF_FFDE);
    do_op(1'b0, 3'b100, 32'h0000_2007, 32'h0, 0, got);
    chk("lbu_2007", got, 32'h0000_00DE);
    do_op(1'b0, 3'b001, 32'h0000_2006, 32'h0, 0, got);
    chk("lh_2006", got, 32'hFFFF_DEAD);
    do_op(1'b1, 3'b000, 32'h0000_2005, 32'h0000_0012, 0, got);
    do_op(1'b0, 3'b010, 32'h0000_2004, 32'h0, 0, got);
    chk("lw_after_sb", got, 32'hDEAD_12EF);
    do_op(1'b0, 3'b010, 32'h0000_2006, 32'h0, 0, got);
    chk("lw_misaligned_rdata", got, 32'h0);
    do_op(1'b0, 3'b010, 32'h0000_2004, 32'h0, 3, got);
    chk("lw_held", got, 32'hDEAD_12EF);

    for (int n = 0; n < 200; n++) begin
      r_addr = ($urandom & 32'hFFFC_0000) | 32'h0000_2000 | $urandom_range(0, 63);
      r_f3   = 3'($urandom_range(0, 7));
      r_we   = 1'($urandom_range(0, 1));
      do_op(r_we, r_f3, r_addr, $urandom, $urandom_range(0, 2), got);
    end

    // Reset arriving during the ACCESS cycle of a store must suppress the write.
    before_val = ref_load(3'b010, 32'h0000_2008);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_2008; req_wdata = ~before_val;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_pre_access_we", {28'h0, dram_we}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("rst_access_dram_we", {28'h0, dram_we}, 32'h0);
    @(posedge clk); #1;
    chk_reset_outputs("rst_after");
    rst_n = 1'b1;
    #1;
    do_op(1'b0, 3'b010, 32'h0000_2008, 32'h0, 0, got);
    chk("rst_mem_unchanged", got, before_val);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
